// File: rtl/down_counter8_clr_if.sv
`default_nettype none
// ============================================================================
//  Module   : down_counter8_clr_if
//  Purpose  : Control and status bundle of the loadable down-counter/timer.
//             The master drives load/start_stop/data and observes the count
//             and status flags. The slave is the counter itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface down_counter8_clr_if #(
  parameter int W = 8
);
  logic         load;
  logic         start_stop;
  logic [W-1:0] data;
  logic [W-1:0] count;
  logic         zero;
  logic         running;
  logic         done;

  modport master (
    output load, start_stop, data,
    input  count, zero, running, done
  );

  modport slave (
    input  load, start_stop, data,
    output count, zero, running, done
  );
endinterface
`default_nettype wire

// File: rtl/down_counter8_clr.sv
`default_nettype none
// ============================================================================
//  Module   : down_counter8_clr
//  Purpose  : Loadable down-counter/timer built from cascaded 4-bit nibble
//             stages. It counts from a loaded value to zero, then stops and
//             flags expiry with a single-cycle done pulse.
//  Options  : DOWN_COUNTER8_CLR_AUTO_RELOAD_EN - when defined, the last
//             loaded value is reloaded one cycle after each expiry, which
//             gives a periodic done. When undefined, expiry holds at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module down_counter8_clr #(
  parameter int NIBBLES = 2
) (
  input  wire logic          clock,
  input  wire logic          clear,
  down_counter8_clr_if.slave bus
);

  localparam int W = 4 * NIBBLES;

  localparam logic [W-1:0] c_zero = '0;
  localparam logic [W-1:0] c_one  = W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  state_t       w_expire_state;
  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic [W-1:0] w_dec;
  logic         r_done;
  logic         w_done_nxt;
  logic         w_cnt_zero;
  logic         w_cnt_one;

  // w_borrow[k] is high when every nibble below k is zero. Nibble k only
  // steps down in that case, and the lower nibbles wrap 0 -> F at the same time.
  logic [NIBBLES-1:0] w_borrow;

  genvar k;
  generate
    for (k = 0; k < NIBBLES; k = k + 1) begin : g_nib
      if (k == 0) begin : g_lsn
        assign w_borrow[k] = 1'b1;
      end else begin : g_upper
        assign w_borrow[k] = w_borrow[k-1] & (r_count[4*(k-1) +: 4] == 4'h0);
      end
      assign w_dec[4*k +: 4] = w_borrow[k] ? (r_count[4*k +: 4] - 4'h1)
                                           : r_count[4*k +: 4];
    end
  endgenerate

  assign w_cnt_zero = (r_count == c_zero);
  assign w_cnt_one  = (r_count == c_one);

`ifdef DOWN_COUNTER8_CLR_AUTO_RELOAD_EN
  logic [W-1:0] r_reload;

  // The reload register follows every load. A reload value of zero can never
  // be counted, so in that case expiry parks in DONE as in the plain build.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_reload <= '0;
    end else if (bus.load) begin
      r_reload <= bus.data;
    end
  end

  assign w_expire_state = (r_reload != c_zero) ? RUN : DONE;
`else
  assign w_expire_state = DONE;
`endif

  // State, count and done registers. Clear returns all of them to the idle
  // values at once, without waiting for a clock edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state and next count. Load takes priority over decrement in every
  // state, and it also cancels a pending done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;

    if (bus.load) begin
      w_count_nxt = bus.data;
      if (bus.data == c_zero) begin
        w_state_nxt = IDLE;
      end else if (bus.start_stop) begin
        w_state_nxt = RUN;
      end else begin
        w_state_nxt = HOLD;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_count_nxt = '0;
        end

        RUN: begin
          if (w_cnt_zero) begin
            // A zero count in RUN is the cycle after an auto-reload expiry.
`ifdef DOWN_COUNTER8_CLR_AUTO_RELOAD_EN
            w_count_nxt = r_reload;
            w_state_nxt = bus.start_stop ? RUN : HOLD;
`else
            w_state_nxt = DONE;
`endif
          end else if (!bus.start_stop) begin
            w_state_nxt = HOLD;
          end else begin
            w_count_nxt = w_dec;
            if (w_cnt_one) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = w_expire_state;
            end
          end
        end

        HOLD: begin
          // Re-arming only changes state. The first decrement comes one edge later.
          if (bus.start_stop) begin
            w_state_nxt = RUN;
          end
        end

        DONE: begin
          w_count_nxt = '0;
        end

        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  assign bus.count   = r_count;
  assign bus.zero    = w_cnt_zero;
  assign bus.running = (r_state == RUN);
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_down_counter8_clr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_down_counter8_clr
//  Purpose  : Self-checking bench for down_counter8_clr. It runs directed
//             scenarios, then a random phase, against a behavioural timer
//             model. A second instance with 3 nibbles checks wide borrows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_down_counter8_clr;

`ifdef DOWN_COUNTER8_CLR_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear = 1'b1;

  always #5 clock = ~clock;

  down_counter8_clr_if #(.W(8))  bif();
  down_counter8_clr_if #(.W(12)) bif3();

  down_counter8_clr #(.NIBBLES(2)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bif)
  );

  down_counter8_clr #(.NIBBLES(3)) dut3 (
    .clock (clock),
    .clear (clear),
    .bus   (bif3)
  );

  int n_chk = 0;
  int n_err = 0;

  // Timer model: cnt is the value, live means a countdown is in progress
  // (loaded and not yet expired), run means the timer is armed this cycle.
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_live = 1'b0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt  = 0;
    m_rel  = 0;
    m_live = 1'b0;
    m_run  = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic void model_edge(input bit ld, input bit ss, input int d);
    m_done = 1'b0;
    if (ld) begin
      m_cnt  = d;
      m_rel  = d;
      m_live = (d != 0);
      m_run  = m_live && ss;
    end else if (m_live) begin
      if (m_run && m_cnt == 0) begin
        m_cnt = m_rel;
        m_run = ss;
      end else if (m_run && ss) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          if (!(AUTO && m_rel != 0)) begin
            m_live = 1'b0;
            m_run  = 1'b0;
          end
        end
      end else begin
        m_run = ss;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"},   {24'h0, bif.count},  32'(m_cnt));
    chk({tag, ".zero"},    {31'h0, bif.zero},   {31'h0, m_cnt == 0});
    chk({tag, ".running"}, {31'h0, bif.running}, {31'h0, m_run});
    chk({tag, ".done"},    {31'h0, bif.done},   {31'h0, m_done});
  endtask

  task automatic step(input string tag, input bit ld, input bit ss, input logic [7:0] d);
    bif.load       = ld;
    bif.start_stop = ss;
    bif.data       = d;
    @(posedge clock);
    model_edge(ld, ss, int'(d));
    #1;
    check_all(tag);
  endtask

  // Asynchronous clear pulsed between clock edges.
  task automatic pulse_clear(input string tag);
    bif.load = 1'b0;
    #1 clear = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 clear = 1'b0;
  endtask

  initial begin
    bif.load        = 1'b0;
    bif.start_stop  = 1'b0;
    bif.data        = '0;
    bif3.load       = 1'b0;
    bif3.start_stop = 1'b0;
    bif3.data       = '0;

    // Reset state while clear is asserted
    #1;
    model_reset();
    check_all("reset");
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    step("idle_after_reset", 1'b0, 1'b1, 8'h00);

    // Clear in the middle of a countdown at 0x37
    step("load37", 1'b1, 1'b0, 8'h37);
    pulse_clear("clear_mid");
    step("post_clear", 1'b0, 1'b1, 8'h00);

    // Load 5 and run to expiry, then observe 10 more cycles
    step("load05", 1'b1, 1'b1, 8'h05);
    for (int i = 0; i < 5; i++) step("run05", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) step("after05", 1'b0, 1'b1, 8'h00);

    // Nibble borrow 0x10 -> 0x0F
    step("load10", 1'b1, 1'b1, 8'h10);
    step("borrow10", 1'b0, 1'b1, 8'h00);
    step("borrow10b", 1'b0, 1'b1, 8'h00);

    // Pause and resume
    step("load0A", 1'b1, 1'b1, 8'h0A);
    for (int i = 0; i < 3; i++) step("run0A", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step("pause", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) step("resume", 1'b0, 1'b1, 8'h00);

    // Load beats expiry, then load of zero goes idle
    step("load02", 1'b1, 1'b1, 8'h02);
    step("run02", 1'b0, 1'b1, 8'h00);
    step("load_wins", 1'b1, 1'b1, 8'h09);
    step("load00", 1'b1, 1'b1, 8'h00);
    step("idle_ss", 1'b0, 1'b1, 8'h00);
    step("idle_ss2", 1'b0, 1'b1, 8'h00);

    // Expiry behaviour, periodic with auto-reload or a single done without it
    step("load03", 1'b1, 1'b1, 8'h03);
    for (int i = 0; i < 12; i++) step("period03", 1'b0, 1'b1, 8'h00);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      bit         ld;
      bit         ss;
      logic [7:0] d;
      if ($urandom_range(0, 79) == 0) begin
        pulse_clear("rnd_clear");
      end
      ld = ($urandom_range(0, 11) == 0);
      ss = ($urandom_range(0, 4) != 0);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 9));
      step("rnd", ld, ss, d);
    end

    // Three-nibble instance: 0x100 borrows through two nibbles
    bif3.load       = 1'b1;
    bif3.start_stop = 1'b1;
    bif3.data       = 12'h100;
    @(posedge clock);
    #1;
    chk("w12.load", {20'h0, bif3.count}, 32'h100);
    bif3.load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock);
      #1;
      chk("w12.dec", {20'h0, bif3.count}, 32'h100 - 32'(i));
    end
    chk("w12.running", {31'h0, bif3.running}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
